// File: rtl/button_debounce_if.sv
// Button pin/debounced-output bundle between the board KEY pins and the button PIO.
// master drives the raw pins; slave is the debouncer that produces the clean level and pulses.
interface button_debounce_if #(
   parameter int NUM_BTN = 3
);
   logic [NUM_BTN-1:0] btn_raw;
   logic [NUM_BTN-1:0] btn_level;
   logic [NUM_BTN-1:0] btn_press_pulse;
   logic [NUM_BTN-1:0] btn_release_pulse;

   modport master (
      output btn_raw,
      input  btn_level,
      input  btn_press_pulse,
      input  btn_release_pulse
   );

   modport slave (
      input  btn_raw,
      output btn_level,
      output btn_press_pulse,
      output btn_release_pulse
   );
endinterface

// File: rtl/button_debounce.sv
// Per-channel two-flop synchroniser, stability-counter debouncer and polarity normaliser
// producing a clean pressed level plus one-cycle press/release pulses.
module button_debounce #(
   parameter int NUM_BTN       = 3,
   parameter int CNT_WIDTH     = 20,
   parameter int STABLE_CYCLES = 500000,
   parameter int ACTIVE_LOW    = 1
) (
   input logic               clk,
   input logic               reset_n,
   button_debounce_if.slave  btn
);

   localparam logic [NUM_BTN-1:0]   RELEASED_RAW = (ACTIVE_LOW != 0) ? '1 : '0;
   localparam logic [CNT_WIDTH-1:0] LAST_CNT     = CNT_WIDTH'(STABLE_CYCLES - 1);

   logic [NUM_BTN-1:0]   sync1;
   logic [NUM_BTN-1:0]   sync2;
   logic [NUM_BTN-1:0]   sync_pressed;
   logic [NUM_BTN-1:0]   level;
   logic [NUM_BTN-1:0]   press_pulse;
   logic [NUM_BTN-1:0]   rel_pulse;
   logic [CNT_WIDTH-1:0] cnt [NUM_BTN];

   // Synchroniser resets to the released pin level so reset release never looks like a press.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= RELEASED_RAW;
         sync2 <= RELEASED_RAW;
      end else begin
         sync1 <= btn.btn_raw;
         sync2 <= sync1;
      end
   end

   assign sync_pressed = sync2 ^ RELEASED_RAW;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         level       <= '0;
         press_pulse <= '0;
         rel_pulse   <= '0;
         for (int unsigned i = 0; i < NUM_BTN; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         press_pulse <= '0;
         rel_pulse   <= '0;
         for (int unsigned i = 0; i < NUM_BTN; i++) begin
            if (sync_pressed[i] == level[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == LAST_CNT) begin
               level[i]       <= sync_pressed[i];
               cnt[i]         <= '0;
               press_pulse[i] <= sync_pressed[i];
               rel_pulse[i]   <= ~sync_pressed[i];
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   assign btn.btn_level         = level;
   assign btn.btn_press_pulse   = press_pulse;
   assign btn.btn_release_pulse = rel_pulse;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with STABLE_CYCLES=8, ACTIVE_LOW=1, NUM_BTN=3.
module tb_button_debounce;

   logic clk;
   logic reset_n;
   int   checks;
   int   errors;

   button_debounce_if #(.NUM_BTN(3)) bus ();

   button_debounce #(
      .NUM_BTN      (3),
      .CNT_WIDTH    (4),
      .STABLE_CYCLES(8),
      .ACTIVE_LOW   (1)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .btn    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges, then settle 1 ns past the edge for driving and sampling.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [2:0] lvl, input logic [2:0] pr,
                      input logic [2:0] rl);
      logic [8:0] obs;
      logic [8:0] exp;
      obs = {bus.btn_level, bus.btn_press_pulse, bus.btn_release_pulse};
      exp = {lvl, pr, rl};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed lvl/press/rel=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic quiet(input string tag, input int n, input logic [2:0] lvl);
      for (int i = 0; i < n; i++) begin
         step(1);
         chk(tag, lvl, 3'b000, 3'b000);
      end
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      reset_n     = 1'b0;
      bus.btn_raw = 3'b111;

      // 1. Reset with all buttons released
      #23;
      chk("in_reset", 3'b000, 3'b000, 3'b000);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      quiet("post_reset", 50, 3'b000);

      // 2. Clean press/release on channel 0
      bus.btn_raw = 3'b110;
      quiet("press0_wait", 9, 3'b000);
      step(1);
      chk("press0_edge", 3'b001, 3'b001, 3'b000);
      step(1);
      chk("press0_after", 3'b001, 3'b000, 3'b000);
      bus.btn_raw = 3'b111;
      quiet("rel0_wait", 9, 3'b001);
      step(1);
      chk("rel0_edge", 3'b000, 3'b000, 3'b001);
      step(1);
      chk("rel0_after", 3'b000, 3'b000, 3'b000);

      // 3. Short glitch on channel 1 rejected, then a long press accepted
      bus.btn_raw = 3'b101;
      quiet("glitch1_low", 5, 3'b000);
      bus.btn_raw = 3'b111;
      quiet("glitch1_high", 15, 3'b000);
      bus.btn_raw = 3'b101;
      quiet("press1_wait", 9, 3'b000);
      step(1);
      chk("press1_edge", 3'b010, 3'b010, 3'b000);
      step(1);
      chk("press1_after", 3'b010, 3'b000, 3'b000);
      step(1);
      bus.btn_raw = 3'b111;
      quiet("rel1_wait", 9, 3'b010);
      step(1);
      chk("rel1_edge", 3'b000, 3'b000, 3'b010);
      step(1);
      chk("rel1_after", 3'b000, 3'b000, 3'b000);

      // 4. Bouncing channel 0 produces exactly one press after settling
      for (int i = 0; i < 5; i++) begin
         bus.btn_raw = 3'b110;
         quiet("bounce_low", 3, 3'b000);
         bus.btn_raw = 3'b111;
         quiet("bounce_high", 3, 3'b000);
      end
      bus.btn_raw = 3'b110;
      quiet("settle_wait", 9, 3'b000);
      step(1);
      chk("settle_edge", 3'b001, 3'b001, 3'b000);
      quiet("settle_hold", 5, 3'b001);
      bus.btn_raw = 3'b111;
      quiet("settle_rel_wait", 9, 3'b001);
      step(1);
      chk("settle_rel_edge", 3'b000, 3'b000, 3'b001);
      step(1);
      chk("settle_rel_after", 3'b000, 3'b000, 3'b000);

      // 5. All channels together
      bus.btn_raw = 3'b000;
      quiet("all_press_wait", 9, 3'b000);
      step(1);
      chk("all_press_edge", 3'b111, 3'b111, 3'b000);
      step(1);
      chk("all_press_after", 3'b111, 3'b000, 3'b000);
      bus.btn_raw = 3'b111;
      quiet("all_rel_wait", 9, 3'b111);
      step(1);
      chk("all_rel_edge", 3'b000, 3'b000, 3'b111);
      step(1);
      chk("all_rel_after", 3'b000, 3'b000, 3'b000);

      // 6. Asynchronous reset while channel 0 pressed and channel 2 counting
      bus.btn_raw = 3'b110;
      step(10);
      chk("pre_rst_press", 3'b001, 3'b001, 3'b000);
      step(1);
      bus.btn_raw = 3'b010;
      quiet("pre_rst_count", 7, 3'b001);
      reset_n = 1'b0;
      #1;
      chk("async_reset", 3'b000, 3'b000, 3'b000);
      #20;
      chk("reset_hold", 3'b000, 3'b000, 3'b000);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      quiet("repress_wait", 9, 3'b000);
      step(1);
      chk("repress_edge", 3'b101, 3'b101, 3'b000);
      step(1);
      chk("repress_after", 3'b101, 3'b000, 3'b000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
